// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use stalls, branch flushes,
// multi-cycle mul wait state and saturating stall/flush performance counters.
`default_nettype none

module pipeline_hazard_sequencer #(
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsMul,
    input  logic             EX_R_Enable,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             EX_BranchTaken,
    input  logic             CntClear,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Busy,
    output logic             State,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int              WAIT_W    = (MUL_CYCLES > 0) ? $clog2(MUL_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MUL_CYCLES);
    localparam bit              MUL_EN    = (MUL_CYCLES > 0);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mul_issue;

    always_comb begin
        load_use = EX_R_Enable && EX_RegWrite && (EX_WriteReg != 5'd0) &&
                   ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                    (ID_UsesRt && (ID_Rt == EX_WriteReg)));
    end

    // A mul only issues when neither a taken branch nor a load-use stall claims the cycle.
    assign mul_issue = MUL_EN && ID_IsMul && !EX_BranchTaken && !load_use;

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Busy         = 1'b0;
        if (!Reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (state_q == MUL_WAIT) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            Busy         = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (load_use) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign State = state_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mul_issue) begin
                        state_q  <= MUL_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                MUL_WAIT: begin
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state_q  <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                default: begin
                    state_q  <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Counters saturate at all-ones; a clear wins over that cycle's increment.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (CntClear) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PCWrite && (StallCount != {CNT_W{1'b1}}))
                StallCount <= StallCount + CNT_W'(1);
            if (IF_ID_Flush && (FlushCount != {CNT_W{1'b1}}))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed self-checking bench for pipeline_hazard_sequencer (MUL_CYCLES=3, CNT_W=4).
`default_nettype none

module tb_pipeline_hazard_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_WriteReg = '0;
    logic       ID_UsesRs = 0, ID_UsesRt = 0, ID_IsMul = 0;
    logic       EX_R_Enable = 0, EX_RegWrite = 0, EX_BranchTaken = 0, CntClear = 0;
    logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Busy, State;
    logic [3:0] StallCount, FlushCount;
    logic       nm_pcw, nm_ifw, nm_bub, nm_flush, nm_busy, nm_state;
    logic [3:0] nm_stall, nm_fcnt;
    logic       bt_in_wait = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_sequencer #(.MUL_CYCLES(3), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsMul(ID_IsMul),
        .EX_R_Enable(EX_R_Enable), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .EX_BranchTaken(EX_BranchTaken), .CntClear(CntClear),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .Busy(Busy), .State(State),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Same stimulus, mul wait state disabled.
    pipeline_hazard_sequencer #(.MUL_CYCLES(0), .CNT_W(4)) dut_nomul (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsMul(ID_IsMul),
        .EX_R_Enable(EX_R_Enable), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .EX_BranchTaken(EX_BranchTaken), .CntClear(CntClear),
        .PCWrite(nm_pcw), .IF_ID_Write(nm_ifw), .ID_EX_Bubble(nm_bub),
        .IF_ID_Flush(nm_flush), .Busy(nm_busy), .State(nm_state),
        .StallCount(nm_stall), .FlushCount(nm_fcnt)
    );

    always @(negedge Clk)
        if (Reset && State && EX_BranchTaken) bt_in_wait <= 1'b1;

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_Rs = '0; ID_Rt = '0; EX_WriteReg = '0;
        ID_UsesRs = 0; ID_UsesRt = 0; ID_IsMul = 0;
        EX_R_Enable = 0; EX_RegWrite = 0; EX_BranchTaken = 0; CntClear = 0;
    endtask

    task automatic drive_lu(input logic [4:0] reg_n);
        EX_R_Enable = 1; EX_RegWrite = 1; EX_WriteReg = reg_n;
        ID_Rs = reg_n; ID_UsesRs = 1;
    endtask

    task automatic test_reset();
        Reset = 0; EX_BranchTaken = 1; ID_IsMul = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite: got %b want 0", PCWrite); end
            checks++; if (IF_ID_Write !== 1'b0) begin errors++; $display("FAIL reset_ifid_write: got %b want 0", IF_ID_Write); end
            checks++; if (ID_EX_Bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble: got %b want 1", ID_EX_Bubble); end
            checks++; if (IF_ID_Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", IF_ID_Flush); end
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
            checks++; if (StallCount !== 4'd0 || FlushCount !== 4'd0) begin errors++; $display("FAIL reset_counts: got stall=%0d flush=%0d want 0/0", StallCount, FlushCount); end
        end
        next_cycle();
        clear_inputs();
        Reset = 1;
        #1;
        checks++; if (State !== 1'b0) begin errors++; $display("FAIL release_state: got %b want 0", State); end
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL release_pcwrite: got %b want 1", PCWrite); end
        checks++; if (ID_EX_Bubble !== 1'b0) begin errors++; $display("FAIL release_bubble: got %b want 0", ID_EX_Bubble); end
    endtask

    task automatic test_load_use();
        drive_lu(5'd8);
        @(negedge Clk);
        checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL lu_pcwrite: got %b want 0", PCWrite); end
        checks++; if (IF_ID_Write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write: got %b want 0", IF_ID_Write); end
        checks++; if (ID_EX_Bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", ID_EX_Bubble); end
        next_cycle();
        clear_inputs();
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL lu_stallcount: got %0d want 1", StallCount); end

        drive_lu(5'd0);
        @(negedge Clk);
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_r0_pcwrite: got %b want 1", PCWrite); end
        next_cycle();
        clear_inputs();
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL lu_r0_stallcount: got %0d want 1", StallCount); end

        EX_R_Enable = 1; EX_RegWrite = 1; EX_WriteReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1;
        @(negedge Clk);
        checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL lu_rt_pcwrite: got %b want 0", PCWrite); end
        next_cycle();
        clear_inputs();
        checks++; if (StallCount !== 4'd2) begin errors++; $display("FAIL lu_rt_stallcount: got %0d want 2", StallCount); end

        EX_RegWrite = 1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1;
        @(negedge Clk);
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_noload_pcwrite: got %b want 1", PCWrite); end
        drive_lu(5'd8);
        ID_UsesRs = 0;
        #1;
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_unused_rs_pcwrite: got %b want 1", PCWrite); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mul();
        ID_IsMul = 1;
        @(negedge Clk);
        checks++; if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1) begin errors++; $display("FAIL mul_issue_write: got pcw=%b ifw=%b want 1/1", PCWrite, IF_ID_Write); end
        checks++; if (ID_EX_Bubble !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mul_issue_bubble_busy: got %b/%b want 0/0", ID_EX_Bubble, Busy); end
        next_cycle();
        ID_IsMul = 0;
        drive_lu(5'd12);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++; if (Busy !== 1'b1 || State !== 1'b1) begin errors++; $display("FAIL mul_wait%0d_busy_state: got %b/%b want 1/1", i, Busy, State); end
            checks++; if (PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1) begin errors++; $display("FAIL mul_wait%0d_pcw_bubble: got %b/%b want 0/1", i, PCWrite, ID_EX_Bubble); end
            if (i == 0) begin
                checks++; if (nm_busy !== 1'b0 || nm_state !== 1'b0) begin errors++; $display("FAIL mul0_busy_state: got %b/%b want 0/0", nm_busy, nm_state); end
            end
            next_cycle();
        end
        @(negedge Clk);
        checks++; if (State !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mul_done_state_busy: got %b/%b want 0/0", State, Busy); end
        checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL mul_then_lu_pcwrite: got %b want 0", PCWrite); end
        next_cycle();
        clear_inputs();
        checks++; if (StallCount !== 4'd6) begin errors++; $display("FAIL mul_stallcount: got %0d want 6", StallCount); end
    endtask

    task automatic test_simultaneous();
        EX_BranchTaken = 1;
        drive_lu(5'd5);
        ID_IsMul = 1;
        @(negedge Clk);
        checks++; if (IF_ID_Flush !== 1'b1) begin errors++; $display("FAIL sim_flush: got %b want 1", IF_ID_Flush); end
        checks++; if (PCWrite !== 1'b1 || IF_ID_Write !== 1'b1 || ID_EX_Bubble !== 1'b1) begin errors++; $display("FAIL sim_ctrl: got pcw=%b ifw=%b bub=%b want 1/1/1", PCWrite, IF_ID_Write, ID_EX_Bubble); end
        next_cycle();
        clear_inputs();
        checks++; if (State !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL sim_state: got %b/%b want 0/0", State, Busy); end
        checks++; if (FlushCount !== 4'd1 || StallCount !== 4'd6) begin errors++; $display("FAIL sim_counts: got flush=%0d stall=%0d want 1/6", FlushCount, StallCount); end
    endtask

    task automatic test_reset_mid_mul();
        ID_IsMul = 1;
        next_cycle();
        ID_IsMul = 0;
        next_cycle();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", Busy); end
        Reset = 0;
        #1;
        checks++; if (PCWrite !== 1'b0 || ID_EX_Bubble !== 1'b1 || IF_ID_Flush !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got pcw=%b bub=%b fl=%b want 0/1/0", PCWrite, ID_EX_Bubble, IF_ID_Flush); end
        checks++; if (Busy !== 1'b0 || State !== 1'b0) begin errors++; $display("FAIL midrst_busy_state: got %b/%b want 0/0", Busy, State); end
        checks++; if (StallCount !== 4'd0 || FlushCount !== 4'd0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", StallCount, FlushCount); end
        next_cycle();
        Reset = 1;
        #1;
        checks++; if (State !== 1'b0 || Busy !== 1'b0 || PCWrite !== 1'b1) begin errors++; $display("FAIL midrst_release: got st=%b busy=%b pcw=%b want 0/0/1", State, Busy, PCWrite); end
        next_cycle();
        checks++; if (StallCount !== 4'd0 || FlushCount !== 4'd0) begin errors++; $display("FAIL midrst_release_counts: got %0d/%0d want 0/0", StallCount, FlushCount); end
    endtask

    task automatic test_saturation();
        drive_lu(5'd3);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 10) begin
                checks++; if (StallCount !== 4'd10) begin errors++; $display("FAIL sat_mid: got %0d want 10", StallCount); end
            end
        end
        checks++; if (StallCount !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", StallCount); end
        CntClear = 1;
        next_cycle();
        checks++; if (StallCount !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", StallCount); end
        CntClear = 0;
        next_cycle();
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL sat_after_clear: got %0d want 1", StallCount); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_simultaneous();
        test_reset_mid_mul();
        test_saturation();
        checks++; if (bt_in_wait !== 1'b0) begin errors++; $display("FAIL branch_in_mul_wait: got %b want 0", bt_in_wait); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline.
- Sits beside the instruction decode controller. Consumes decoded ID-stage register usage, EX-stage load/writeback info and branch resolution.
- Drives PC write enable, IF/ID write enable, ID/EX bubble insertion and IF/ID flush.
- Sequences the multi-cycle SPECIAL2 mul with a wait state. Keeps saturating stall and flush performance counters.

Parameters:
- MUL_CYCLES, 3, number of extra cycles younger instructions are held after a mul issues (0 disables the wait state).
- CNT_W, 16, width of the performance counters.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  the ID instruction reads rs.
- ID_UsesRt  in  1  the ID instruction reads rt.
- ID_IsMul  in  1  the ID instruction is SPECIAL2 mul.
- EX_R_Enable  in  1  the EX instruction is a load.
- EX_RegWrite  in  1  the EX instruction writes a register.
- EX_WriteReg  in  5  destination register of the EX instruction.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- CntClear  in  1  synchronous clear of both counters.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- ID_EX_Bubble  out  1  zero the control bits entering ID/EX.
- IF_ID_Flush  out  1  clear IF/ID to a nop.
- Busy  out  1  high while in MUL_WAIT.
- State  out  1  0 = RUN, 1 = MUL_WAIT.
- StallCount  out  CNT_W  cycles with PCWrite = 0, excluding reset.
- FlushCount  out  CNT_W  cycles with IF_ID_Flush = 1.

Behaviour:
- Reset low (async, takes effect immediately):
  - State = RUN, wait counter = 0, StallCount = FlushCount = 0.
  - Outputs forced: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, IF_ID_Flush = 0, Busy = 0.
  - Reset asserted mid-MUL_WAIT aborts the wait; the first cycle after deassertion is RUN.
- Outputs are combinational from the current state and current inputs (zero latency). State and counters update on the rising Clk edge.
- Load-use hazard: LU = EX_R_Enable & EX_RegWrite & (EX_WriteReg != 0) & ((ID_UsesRs & ID_Rs == EX_WriteReg) | (ID_UsesRt & ID_Rt == EX_WriteReg)).
- RUN, priority order:
  1. EX_BranchTaken: PCWrite = 1, IF_ID_Write = 1, IF_ID_Flush = 1, ID_EX_Bubble = 1. LU and ID_IsMul are ignored. Stay in RUN.
  2. LU: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, IF_ID_Flush = 0. Stay in RUN. A mul in ID is not issued this cycle.
  3. ID_IsMul with MUL_CYCLES > 0: normal outputs (PCWrite = 1, IF_ID_Write = 1, ID_EX_Bubble = 0, IF_ID_Flush = 0). The mul issues. Next state MUL_WAIT, wait counter loaded with MUL_CYCLES.
  4. Otherwise: normal outputs, stay in RUN.
- MUL_WAIT:
  - Outputs: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, IF_ID_Flush = 0, Busy = 1.
  - Wait counter decrements each cycle. When it reaches 1, the next state is RUN. MUL_WAIT therefore lasts exactly MUL_CYCLES cycles.
  - EX_BranchTaken and LU are ignored: EX holds only bubbles in this state. The bench flags EX_BranchTaken = 1 in MUL_WAIT as an assertion error.
- A mul followed by a dependent load-use sequence is serialised: MUL_WAIT completes first, then LU is evaluated in RUN.
- MUL_CYCLES = 0: mul is treated as a single-cycle op and MUL_WAIT is unreachable.
- Counters:
  - StallCount increments on every edge where Reset is high and PCWrite = 0.
  - FlushCount increments on every edge where IF_ID_Flush = 1.
  - Both saturate at all-ones with no wrap.
  - CntClear = 1 zeroes both on the edge and overrides that cycle's increment.
- Register $0 never creates a hazard.

Test Plan:
- Reset low for 3 cycles, with EX_BranchTaken = 1 and ID_IsMul = 1 driven -> PCWrite = 0, ID_EX_Bubble = 1, IF_ID_Flush = 0, StallCount = 0, FlushCount = 0. Release -> State = RUN, PCWrite = 1.
- Load-use: EX_R_Enable = 1, EX_RegWrite = 1, EX_WriteReg = 8, ID_Rs = 8, ID_UsesRs = 1 for one cycle -> PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1 that cycle, StallCount = 1 after the edge. Same stimulus with EX_WriteReg = 0 -> no stall.
- Mul issue with MUL_CYCLES = 3: ID_IsMul = 1 in RUN -> issue cycle has normal outputs. Next 3 cycles show Busy = 1 and PCWrite = 0. The 4th cycle is RUN. StallCount = 3.
- Simultaneous events: EX_BranchTaken = 1 with LU true and ID_IsMul = 1 -> IF_ID_Flush = 1, PCWrite = 1, State stays RUN, FlushCount increments by 1.
- Reset pulsed low during the 2nd MUL_WAIT cycle -> outputs forced to reset values immediately. After release: State = RUN, Busy = 0, counters = 0.
- Saturation with CNT_W = 4: hold LU for 20 cycles -> StallCount stops at 15. Then CntClear = 1 with LU still high -> StallCount = 0 after the edge.
